// File: rtl/adat_pkg.sv
// Shared types and constants for the ADAT->I2S frame buffer path.
//   adat_link_state_e : link supervisor states
//   ADAT_FRAME_BITS   : bits per circular-buffer frame slot
package adat_pkg;

    localparam int ADAT_FRAME_BITS = 256;

    typedef enum logic [1:0] {
        StUnlocked  = 2'd0,
        StAcquiring = 2'd1,
        StLocked    = 2'd2,
        StHoldoff   = 2'd3
    } adat_link_state_e;

endpackage

// File: rtl/frame_watchdog.sv
// Reloadable interval counter used as the frame watchdog.
//   clk_i     : clock
//   rst_ni    : synchronous active-low reset (count returns to 0)
//   reload_i  : restart the interval from 0
//   expired_o : high for the one cycle in which LIMIT cycles have elapsed
//               since the last reload; the count restarts on the next edge
module frame_watchdog #(
    parameter int unsigned LIMIT = 300
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic reload_i,
    output logic expired_o
);

    localparam int W = (LIMIT > 2) ? $clog2(LIMIT) : 1;
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt_q;

    // Independent of reload_i so the caller can derive reload from the
    // expiry without forming a combinational loop.
    assign expired_o = (cnt_q == LAST);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (reload_i || expired_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/adat_frame_buffer_ctrl.sv
// Write-side slot allocator and link supervisor for the ADAT->I2S circular
// frame buffer.
//   clk_i, rst_ni         : clock, synchronous active-low reset
//   frame_done_i          : pulse, receiver finished slot write_frame_o
//   frame_good_i          : qualifies frame_done_i
//   tx_read_frame_i       : slot the transmitter is reading
//   tx_running_i          : transmitter running
//   write_frame_o         : slot the receiver writes next
//   last_good_frame_idx_o : newest complete good slot
//   resync_req_o          : high while locked; low stops the transmitter
//   locked_o              : link locked
//   overrun_o             : one-cycle pulse on write/read slot collision
//   err_count_o           : saturating count of bad frames, timeouts, overruns
//   state_o               : supervisor state (debug)
// Handshake: frame_done_i is a single-cycle strobe with no back-pressure;
// every cycle it is high is one frame event, qualified by frame_good_i.
module adat_frame_buffer_ctrl
    import adat_pkg::*;
#(
    parameter int CIRC_BUF_BITS  = 3,
    parameter int LOCK_FRAMES    = 4,
    parameter int UNLOCK_FRAMES  = 3,
    parameter int TIMEOUT_CYCLES = 300,
    parameter int HOLDOFF_CYCLES = 512
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     frame_done_i,
    input  logic                     frame_good_i,
    input  logic [CIRC_BUF_BITS-1:0] tx_read_frame_i,
    input  logic                     tx_running_i,
    output logic [CIRC_BUF_BITS-1:0] write_frame_o,
    output logic [CIRC_BUF_BITS-1:0] last_good_frame_idx_o,
    output logic                     resync_req_o,
    output logic                     locked_o,
    output logic                     overrun_o,
    output logic [7:0]               err_count_o,
    output adat_link_state_e         state_o
);

    localparam int HW = (HOLDOFF_CYCLES > 2) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_CYCLES - 1);

    adat_link_state_e state_q, state_d;
    logic [3:0]    good_cnt_q, good_cnt_d;
    logic [3:0]    bad_cnt_q, bad_cnt_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [CIRC_BUF_BITS-1:0] write_q, last_q;
    logic [7:0]    err_q;
    logic          overrun_q;

    logic wd_expired, wd_reload;
    logic good_ev, bad_ev, timeout_ev, overrun_ev, err_ev;

    assign good_ev    = frame_done_i & frame_good_i;
    assign bad_ev     = frame_done_i & ~frame_good_i;
    // A frame arriving on the expiry cycle wins; no timeout is counted.
    assign timeout_ev = wd_expired & ~frame_done_i;
    assign overrun_ev = (state_q == StLocked) & tx_running_i & good_ev &
                        ((write_q + 1'b1) == tx_read_frame_i);
    assign err_ev     = bad_ev | timeout_ev | overrun_ev;

    assign wd_reload  = frame_done_i |
                        ((state_d == StUnlocked) && (state_q != StUnlocked));

    frame_watchdog #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .reload_i (wd_reload),
        .expired_o(wd_expired)
    );

    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        hold_cnt_d = hold_cnt_q;
        unique case (state_q)
            StUnlocked: begin
                if (good_ev) begin
                    if (LOCK_FRAMES == 1) begin
                        state_d    = StLocked;
                        good_cnt_d = '0;
                        bad_cnt_d  = '0;
                    end else begin
                        state_d    = StAcquiring;
                        good_cnt_d = 4'd1;
                    end
                end
            end
            StAcquiring: begin
                if (good_ev) begin
                    if ((good_cnt_q + 4'd1) == 4'(LOCK_FRAMES)) begin
                        state_d    = StLocked;
                        good_cnt_d = '0;
                        bad_cnt_d  = '0;
                    end else begin
                        good_cnt_d = good_cnt_q + 4'd1;
                    end
                end else if (bad_ev || timeout_ev) begin
                    state_d    = StUnlocked;
                    good_cnt_d = '0;
                end
            end
            StLocked: begin
                if (overrun_ev) begin
                    state_d    = StHoldoff;
                    bad_cnt_d  = '0;
                    hold_cnt_d = '0;
                end else if (good_ev) begin
                    bad_cnt_d = '0;
                end else if (bad_ev || timeout_ev) begin
                    if ((bad_cnt_q + 4'd1) == 4'(UNLOCK_FRAMES)) begin
                        state_d    = StHoldoff;
                        bad_cnt_d  = '0;
                        hold_cnt_d = '0;
                    end else begin
                        bad_cnt_d = bad_cnt_q + 4'd1;
                    end
                end
            end
            StHoldoff: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = StUnlocked;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: state_d = StUnlocked;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= StUnlocked;
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
            hold_cnt_q <= '0;
            write_q    <= '0;
            last_q     <= '0;
            err_q      <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            good_cnt_q <= good_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            overrun_q  <= overrun_ev;
            // Slots advance on every good frame regardless of link state;
            // a bad frame leaves the slot to be rewritten.
            if (good_ev) begin
                last_q  <= write_q;
                write_q <= write_q + 1'b1;
            end
            if (err_ev && (err_q != 8'hFF)) begin
                err_q <= err_q + 8'd1;
            end
        end
    end

    assign write_frame_o         = write_q;
    assign last_good_frame_idx_o = last_q;
    assign resync_req_o          = (state_q == StLocked);
    assign locked_o              = (state_q == StLocked);
    assign overrun_o             = overrun_q;
    assign err_count_o           = err_q;
    assign state_o               = state_q;

endmodule

// File: tb/tb_adat_frame_buffer_ctrl.sv
module tb_adat_frame_buffer_ctrl;
    import adat_pkg::*;

    // clock / reset / stimulus signals
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic frame_done = 1'b0;
    logic frame_good = 1'b0;
    logic [2:0] tx_read = 3'd0;
    logic tx_running = 1'b0;

    logic [2:0] write_frame, last_good;
    logic resync_req, locked, overrun;
    logic [7:0] err_count;
    adat_link_state_e state;

    always #5 clk = ~clk;

    adat_frame_buffer_ctrl dut (
        .clk_i                (clk),
        .rst_ni               (rst_n),
        .frame_done_i         (frame_done),
        .frame_good_i         (frame_good),
        .tx_read_frame_i      (tx_read),
        .tx_running_i         (tx_running),
        .write_frame_o        (write_frame),
        .last_good_frame_idx_o(last_good),
        .resync_req_o         (resync_req),
        .locked_o             (locked),
        .overrun_o            (overrun),
        .err_count_o          (err_count),
        .state_o              (state)
    );

    // scoreboard: {state, write, last_good, resync, locked, overrun, err}
    int total = 0;
    int bad = 0;
    logic [18:0] exp_q[$];

    task automatic push_exp(input adat_link_state_e st, input int wr, input int lg,
                            input logic ov, input int er);
        logic lk;
        logic [2:0] w3, l3;
        logic [7:0] e8;
        lk = (st == StLocked);
        w3 = wr[2:0];
        l3 = lg[2:0];
        e8 = er[7:0];
        exp_q.push_back({st, w3, l3, lk, lk, ov, e8});
    endtask

    task automatic check_out(input string tag);
        logic [18:0] exp_v, obs_v;
        obs_v = {state, write_frame, last_good, resync_req, locked, overrun, err_count};
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL %s: observed=%h but expected queue empty", tag, obs_v);
        end else begin
            exp_v = exp_q.pop_front();
            assert (obs_v === exp_v) else begin
                bad++;
                $error("FAIL %s: observed st=%0d wr=%0d lg=%0d rs=%b lk=%b ov=%b err=%0d expected st=%0d wr=%0d lg=%0d rs=%b lk=%b ov=%b err=%0d",
                       tag, obs_v[18:17], obs_v[16:14], obs_v[13:11], obs_v[10], obs_v[9], obs_v[8], obs_v[7:0],
                       exp_v[18:17], exp_v[16:14], exp_v[13:11], exp_v[10], exp_v[9], exp_v[8], exp_v[7:0]);
            end
        end
    endtask

    // driver tasks; all called at a negedge, outputs sampled at a negedge
    task automatic frame(input logic good, input adat_link_state_e st, input int wr,
                         input int lg, input logic ov, input int er, input string tag);
        push_exp(st, wr, lg, ov, er);
        frame_done = 1'b1;
        frame_good = good;
        @(negedge clk);
        frame_done = 1'b0;
        frame_good = 1'b0;
        check_out(tag);
    endtask

    task automatic idle(input int n, input adat_link_state_e st, input int wr, input int lg,
                        input logic ov, input int er, input string tag);
        push_exp(st, wr, lg, ov, er);
        repeat (n) @(negedge clk);
        check_out(tag);
    endtask

    task automatic gap();
        repeat (255) @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        push_exp(StUnlocked, 0, 0, 1'b0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_out(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        // frame strobe while in reset is ignored
        frame(1'b1, StUnlocked, 0, 0, 1'b0, 0, "done_in_reset");
        rst_n = 1'b1;
        idle(1, StUnlocked, 0, 0, 1'b0, 0, "reset_state");

        // lock acquire
        frame(1'b1, StAcquiring, 1, 0, 1'b0, 0, "acq1"); gap();
        frame(1'b1, StAcquiring, 2, 1, 1'b0, 0, "acq2"); gap();
        frame(1'b1, StAcquiring, 3, 2, 1'b0, 0, "acq3"); gap();
        frame(1'b1, StLocked,    4, 3, 1'b0, 0, "lock");
        repeat (10) @(negedge clk);

        // reset while locked
        do_reset("reset_mid_lock");

        // acquire abort, then relock with index wrap toward 7
        frame(1'b1, StAcquiring, 1, 0, 1'b0, 0, "ab_acq1"); gap();
        frame(1'b1, StAcquiring, 2, 1, 1'b0, 0, "ab_acq2"); gap();
        frame(1'b1, StAcquiring, 3, 2, 1'b0, 0, "ab_acq3"); gap();
        frame(1'b0, StUnlocked,  3, 2, 1'b0, 1, "ab_bad"); gap();
        frame(1'b1, StAcquiring, 4, 3, 1'b0, 1, "re_acq1"); gap();
        frame(1'b1, StAcquiring, 5, 4, 1'b0, 1, "re_acq2"); gap();
        frame(1'b1, StAcquiring, 6, 5, 1'b0, 1, "re_acq3"); gap();
        frame(1'b1, StLocked,    7, 6, 1'b0, 1, "re_lock");

        // watchdog loss: three timeouts drop lock, then 512-cycle holdoff
        idle(899, StLocked,   7, 6, 1'b0, 3, "wd_still_locked");
        idle(1,   StHoldoff,  7, 6, 1'b0, 4, "wd_drop");
        idle(511, StHoldoff,  7, 6, 1'b0, 5, "holdoff_last");
        idle(1,   StUnlocked, 7, 6, 1'b0, 5, "holdoff_exit");

        // overrun
        do_reset("reset_overrun");
        tx_running = 1'b1;
        tx_read = 3'd5;
        frame(1'b1, StAcquiring, 1, 0, 1'b0, 0, "ov_acq1"); gap();
        frame(1'b1, StAcquiring, 2, 1, 1'b0, 0, "ov_acq2"); gap();
        frame(1'b1, StAcquiring, 3, 2, 1'b0, 0, "ov_acq3"); gap();
        frame(1'b1, StLocked,    4, 3, 1'b0, 0, "ov_lock"); gap();
        frame(1'b1, StHoldoff,   5, 4, 1'b1, 1, "overrun");
        idle(1, StHoldoff, 5, 4, 1'b0, 1, "overrun_pulse_end");
        // holdoff: slots still advance, errors still counted, no state change
        frame(1'b1, StHoldoff, 6, 5, 1'b0, 1, "holdoff_good");
        frame(1'b0, StHoldoff, 6, 5, 1'b0, 2, "holdoff_bad");
        tx_running = 1'b0;
        tx_read = 3'd0;

        // error counter saturation
        do_reset("reset_sat");
        for (int i = 0; i < 300; i++) begin
            frame(1'b0, StUnlocked, 0, 0, 1'b0, (i + 1 > 255) ? 255 : i + 1, "sat_bad");
            @(negedge clk);
        end

        // frame on the watchdog expiry cycle: no timeout counted
        do_reset("reset_sim");
        idle(299, StUnlocked, 0, 0, 1'b0, 0, "pre_expiry");
        frame(1'b1, StAcquiring, 1, 0, 1'b0, 0, "coincident_frame");
        idle(299, StAcquiring, 1, 0, 1'b0, 0, "acq_before_timeout");
        idle(1,   StUnlocked,  1, 0, 1'b0, 1, "acq_timeout");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
